// File: rtl/gpio_debounce_pin.sv
// gpio_debounce_pin
//   Debounce state for a single, already synchronised input pin. A new level
//   on i_level must persist for HOLDOFF consecutive prescaler ticks before it
//   is committed to o_level. Any return to the current stable level clears
//   the progress.
// Ports
//   i_clk       system clock
//   i_reset     synchronous, active-high reset
//   i_tick      shared debounce tick from the prescaler
//   i_level     synchronised pin level
//   o_level     debounced stable level (registered)
//   o_rise      1-clk strobe, o_level went 0->1 (registered)
//   o_fall      1-clk strobe, o_level went 1->0 (registered)
//   o_rise_nxt  next-state value of o_rise, for the aggregate change strobe
//   o_fall_nxt  next-state value of o_fall, for the aggregate change strobe
module gpio_debounce_pin #(
  parameter int   HOLDOFF = 3,
  parameter logic INITIAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_level,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam int            CW   = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLDOFF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Hold-off counter and commit decision for this pin.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (i_level != level_q) begin
      if (i_tick) begin
        if (cnt_q == LAST) begin
          // Level persisted long enough: commit and strobe the direction.
          level_d = i_level;
          cnt_d   = {CW{1'b0}};
          rise_d  = i_level;
          fall_d  = ~i_level;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      // Glitch ended (or nothing pending): discard any progress.
      cnt_d = {CW{1'b0}};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= {CW{1'b0}};
      level_q <= INITIAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level    = level_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign o_rise_nxt = rise_d;
  assign o_fall_nxt = fall_d;

endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   Input conditioner for the GPIO controller's pad inputs. Each raw pad is
//   brought into i_clk through a two-flop synchroniser, then debounced by a
//   per-pin hold-off counter advanced by a shared prescaler tick.
// Ports
//   i_clk      system clock
//   i_reset    synchronous, active-high reset
//   i_gpio     [NIN-1:0] raw asynchronous pad inputs
//   o_gpio     [NIN-1:0] debounced stable levels
//   o_rise     [NIN-1:0] 1-clk strobe per pin, 0->1 commit
//   o_fall     [NIN-1:0] 1-clk strobe per pin, 1->0 commit
//   o_changed  1-clk strobe, any pin committed this cycle
module gpio_debounce #(
  parameter int             NIN      = 16,
  parameter int             PRESCALE = 1,
  parameter int             HOLDOFF  = 3,
  parameter logic [NIN-1:0] INITIAL  = {NIN{1'b0}}
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NIN-1:0] i_gpio,
  output logic [NIN-1:0] o_gpio,
  output logic [NIN-1:0] o_rise,
  output logic [NIN-1:0] o_fall,
  output logic           o_changed
);

  logic [NIN-1:0] sync_x_q, sync_x_d;
  logic [NIN-1:0] sync_q_q, sync_q_d;
  logic [NIN-1:0] rise_nxt, fall_nxt;
  logic           changed_q, changed_d;
  logic           tick;

  // Two-flop synchroniser; only the second stage feeds the debouncers.
  always_comb begin
    sync_x_d = i_gpio;
    sync_q_d = sync_x_q;
  end

  // Synchroniser registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_x_q <= INITIAL;
      sync_q_q <= INITIAL;
    end else begin
      sync_x_q <= sync_x_d;
      sync_q_q <= sync_q_d;
    end
  end

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int            PW    = $clog2(PRESCALE);
      localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q, pre_d;

      // Prescaler wraps on the same edge that its tick is consumed.
      always_comb begin
        if (pre_q == PLAST) begin
          pre_d = {PW{1'b0}};
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      // Prescaler register.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          pre_q <= {PW{1'b0}};
        end else begin
          pre_q <= pre_d;
        end
      end

      assign tick = (pre_q == PLAST);
    end
  endgenerate

  generate
    for (genvar i = 0; i < NIN; i++) begin : g_pin
      gpio_debounce_pin #(
        .HOLDOFF (HOLDOFF),
        .INITIAL (INITIAL[i])
      ) u_pin (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick     (tick),
        .i_level    (sync_q_q[i]),
        .o_level    (o_gpio[i]),
        .o_rise     (o_rise[i]),
        .o_fall     (o_fall[i]),
        .o_rise_nxt (rise_nxt[i]),
        .o_fall_nxt (fall_nxt[i])
      );
    end
  endgenerate

  // Aggregate strobe is registered from the pins' next-state strobes so it
  // lines up with o_rise/o_fall.
  always_comb begin
    changed_d = |(rise_nxt | fall_nxt);
  end

  // Aggregate change strobe register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign o_changed = changed_q;

endmodule
